// File: rtl/string_avalon_front_if.sv
// Avalon-MM slave bus plus accelerator go/done handshake, bundled for string_avalon_front.
// slave = the register front end's view; master = the system/accelerator side.
interface string_avalon_front_if #(
    parameter int STR_BYTES = 2,
    parameter int LEN_W     = 2
);
    logic [2:0]             avs_address;
    logic                   avs_read;
    logic                   avs_write;
    logic [31:0]            avs_writedata;
    logic [31:0]            avs_readdata;
    logic                   acc_go;
    logic [2:0]             acc_index;
    logic [8*STR_BYTES-1:0] acc_a;
    logic [8*STR_BYTES-1:0] acc_b;
    logic [LEN_W-1:0]       acc_len_a;
    logic [LEN_W-1:0]       acc_len_b;
    logic                   acc_done;
    logic [8*STR_BYTES-1:0] acc_result;
    logic                   irq;

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata,
        output acc_go, acc_index, acc_a, acc_b, acc_len_a, acc_len_b,
        input  acc_done, acc_result,
        output irq
    );

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata,
        input  acc_go, acc_index, acc_a, acc_b, acc_len_a, acc_len_b,
        output acc_done, acc_result,
        input  irq
    );
endinterface

// File: rtl/string_avalon_front.sv
// Register front end for the string accelerator: operand/ctrl/status regs, go/done handshake, timeout.
// Latency: 1-cycle read data; acc_go rises the cycle after a valid START write. Optional irq: STRING_FRONT_IRQ_EN.
// Backpressure: none on Avalon (no waitrequest); A/B/CTRL writes are dropped while BUSY.
module string_avalon_front #(
    parameter int STR_BYTES = 2,
    parameter int LEN_W     = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic clk,
    input  logic reset,
    string_avalon_front_if.slave bus
);
    localparam int OP_W  = 8 * STR_BYTES;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GO, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [OP_W-1:0]   reg_a, reg_b, result;
    logic [2:0]        idx;
    logic [LEN_W-1:0]  len_a, len_b;
    logic              ie;
    logic              done, err_idx, err_tmo;
    logic [CNT_W-1:0]  cnt, cnt_inc;
    logic              busy;
    logic              wr_a, wr_b, wr_ctrl, wr_clr;
    logic              start_ok, start_bad, capture, timeout;
    logic [31:0]       rd_mux;
    logic              wd_unused;

    assign busy    = (state != IDLE);
    assign cnt_inc = cnt + 1'b1;
    assign wr_a    = bus.avs_write && (bus.avs_address == 3'd0) && !busy;
    assign wr_b    = bus.avs_write && (bus.avs_address == 3'd1) && !busy;
    assign wr_ctrl = bus.avs_write && (bus.avs_address == 3'd2) && !busy;
    assign wr_clr  = bus.avs_write && (bus.avs_address == 3'd4);
    assign wd_unused = &{1'b0, bus.avs_writedata[31:19]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                // An out-of-range index would hang the accelerator, so it never sees go
                if (wr_ctrl && bus.avs_writedata[0]) begin
                    if (bus.avs_writedata[3:1] <= 3'd1) begin
                        start_ok  = 1'b1;
                        state_nxt = GO;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            GO: begin
                if (bus.acc_done) begin
                    capture   = 1'b1;
                    state_nxt = DRAIN;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    timeout   = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!bus.acc_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_a   <= '0;
            reg_b   <= '0;
            idx     <= '0;
            len_a   <= '0;
            len_b   <= '0;
            result  <= '0;
            done    <= 1'b0;
            err_idx <= 1'b0;
            err_tmo <= 1'b0;
            cnt     <= '0;
        end else begin
            if (wr_a) reg_a <= bus.avs_writedata[OP_W-1:0];
            if (wr_b) reg_b <= bus.avs_writedata[OP_W-1:0];
            if (wr_ctrl && !start_bad) begin
                idx   <= bus.avs_writedata[3:1];
                len_a <= bus.avs_writedata[4 +: LEN_W];
                len_b <= bus.avs_writedata[6 +: LEN_W];
            end
            if (capture) result <= bus.acc_result;
            cnt <= (state == GO && state_nxt == GO) ? cnt_inc : '0;
            // Setting a flag outranks a CLEAR in the same cycle
            if (capture)                                done <= 1'b1;
            else if (start_ok)                          done <= 1'b0;
            else if (wr_clr && bus.avs_writedata[16])   done <= 1'b0;
            if (start_bad)                              err_idx <= 1'b1;
            else if (wr_clr && bus.avs_writedata[17])   err_idx <= 1'b0;
            if (timeout)                                err_tmo <= 1'b1;
            else if (wr_clr && bus.avs_writedata[18])   err_tmo <= 1'b0;
        end
    end

`ifdef STRING_FRONT_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie    <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (wr_ctrl && !start_bad) ie <= bus.avs_writedata[9];
            irq_q <= (done | err_idx | err_tmo) & ie;
        end
    end
    assign bus.irq = irq_q;
`else
    assign ie      = 1'b0;
    assign bus.irq = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (bus.avs_address)
            3'd0: rd_mux[OP_W-1:0] = reg_a;
            3'd1: rd_mux[OP_W-1:0] = reg_b;
            3'd2: begin
                rd_mux[3:1]        = idx;
                rd_mux[4 +: LEN_W] = len_a;
                rd_mux[6 +: LEN_W] = len_b;
                rd_mux[8]          = busy;
                rd_mux[9]          = ie;
            end
            3'd3: begin
                rd_mux[OP_W-1:0] = result;
                rd_mux[16]       = done;
                rd_mux[17]       = err_idx;
                rd_mux[18]       = err_tmo;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)             bus.avs_readdata <= '0;
        else if (bus.avs_read) bus.avs_readdata <= rd_mux;
    end

    assign bus.acc_go    = (state == GO);
    assign bus.acc_index = idx;
    assign bus.acc_a     = reg_a;
    assign bus.acc_b     = reg_b;
    assign bus.acc_len_a = len_a;
    assign bus.acc_len_b = len_b;
endmodule

// File: tb/tb_string_avalon_front.sv
// Bench for string_avalon_front: behavioural accelerator model plus read scoreboard.
module tb_string_avalon_front;
    logic clk;
    logic reset;

    string_avalon_front_if #(.STR_BYTES(2), .LEN_W(2)) bif ();

    string_avalon_front #(.STR_BYTES(2), .LEN_W(2), .TIMEOUT(255)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Accelerator model: raises done once go has been high for more than dly cycles
    logic        hang  = 1'b0;
    logic        stray = 1'b0;
    int          dly   = 3;
    int          mcnt  = 0;
    logic [15:0] mres  = 16'h0;

    always @(negedge clk) begin
        if (stray) begin
            bif.acc_done = 1'b1;
        end else if (hang || !bif.acc_go) begin
            bif.acc_done = 1'b0;
            mcnt = 0;
        end else begin
            mcnt++;
            if (mcnt > dly) bif.acc_done = 1'b1;
        end
        bif.acc_result = mres;
    end

    // Length of the most recent acc_go pulse, in cycles
    int run = 0;
    int last_len = 0;
    always @(negedge clk) begin
        if (bif.acc_go) run++;
        else if (run != 0) begin
            last_len = run;
            run = 0;
        end
    end

    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        bif.avs_address   = addr;
        bif.avs_writedata = data;
        bif.avs_write     = 1'b1;
        @(negedge clk);
        bif.avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string tag);
        @(negedge clk);
        bif.avs_address = addr;
        bif.avs_read    = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        bif.avs_read = 1'b0;
        chk(tag_q.pop_front(), bif.avs_readdata, exp_q.pop_front());
    endtask

    task automatic wait_go_low(input string tag);
        int n;
        n = 0;
        while (bif.acc_go && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, bif.acc_go}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int go_seen;
        reset = 1'b1;
        bif.avs_address = '0;
        bif.avs_read = 1'b0;
        bif.avs_write = 1'b0;
        bif.avs_writedata = '0;
        bif.acc_done = 1'b0;
        bif.acc_result = '0;
        #12;
        chk("rst_go", {31'd0, bif.acc_go}, 32'd0);
        chk("rst_rdata", bif.avs_readdata, 32'd0);
        chk("rst_irq", {31'd0, bif.irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) rd(3'(a), 32'd0, $sformatf("rst_reg%0d", a));

        // Compare: go held 4 cycles, result 1
        dly = 3; mres = 16'h0001;
        wr(3'd0, 32'h4142);
        wr(3'd1, 32'h4142);
        wr(3'd2, 32'h51);
        chk("cmp_go", {31'd0, bif.acc_go}, 32'd1);
        chk("cmp_a", bif.acc_a, 32'h4142);
        chk("cmp_b", bif.acc_b, 32'h4142);
        chk("cmp_fields", {bif.acc_index, bif.acc_len_a, bif.acc_len_b}, {25'd0, 3'd0, 2'd1, 2'd1});
        wait_go_low("cmp_go_drop");
        chk("cmp_go_len", last_len, 32'd4);
        rd(3'd2, 32'h50, "cmp_ctrl_idle");
        rd(3'd3, 32'h0001_0001, "cmp_status");
        chk("cmp_irq", {31'd0, bif.irq}, 32'd0);

        // To-upper
        mres = 16'h4142;
        wr(3'd0, 32'h6162);
        wr(3'd2, 32'h13);
        chk("up_index", bif.acc_index, 32'd1);
        wait_go_low("up_go_drop");
        rd(3'd3, 32'h0001_4142, "up_status");
        rd(3'd2, 32'h12, "up_ctrl");

        // Invalid index: no go, ERR_IDX, fields untouched
        wr(3'd2, 32'h05);
        go_seen = 0;
        repeat (6) begin
            if (bif.acc_go) go_seen++;
            @(negedge clk);
        end
        chk("bad_no_go", go_seen, 32'd0);
        rd(3'd3, 32'h0003_4142, "bad_status");
        rd(3'd2, 32'h12, "bad_ctrl");
        wr(3'd4, 32'h20000);
        rd(3'd3, 32'h0001_4142, "bad_clear");

        // Timeout with writes attempted while busy
        hang = 1'b1;
        wr(3'd2, 32'h01);
        rd(3'd2, 32'h100, "tmo_busy");
        wr(3'd0, 32'hFFFF);
        rd(3'd0, 32'h6162, "tmo_a_kept");
        chk("tmo_acc_a", bif.acc_a, 32'h6162);
        rd(3'd3, 32'h0000_4142, "tmo_done_clr");
        wait_go_low("tmo_go_drop");
        chk("tmo_go_len", last_len, 32'd255);
        rd(3'd3, 32'h0004_4142, "tmo_status");
        rd(3'd2, 32'h000, "tmo_ctrl_idle");

        // acc_done in IDLE is ignored
        stray = 1'b1;
        repeat (3) @(negedge clk);
        stray = 1'b0;
        chk("stray_go", {31'd0, bif.acc_go}, 32'd0);
        rd(3'd3, 32'h0004_4142, "stray_status");

        // IE bit is only present with the irq feature
        wr(3'd2, 32'h200);
`ifdef STRING_FRONT_IRQ_EN
        rd(3'd2, 32'h200, "ie_rw");
`else
        rd(3'd2, 32'h000, "ie_absent");
        chk("irq_tied", {31'd0, bif.irq}, 32'd0);
`endif

        // Reset in the middle of GO
        wr(3'd0, 32'h1234);
        wr(3'd2, 32'h01);
        repeat (5) @(negedge clk);
        chk("mid_go", {31'd0, bif.acc_go}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_go", {31'd0, bif.acc_go}, 32'd0);
        chk("mid_rst_a", bif.acc_a, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        hang = 1'b0;
        rd(3'd0, 32'd0, "mid_rst_regA");
        rd(3'd2, 32'd0, "mid_rst_ctrl");
        rd(3'd3, 32'd0, "mid_rst_status");

`ifdef STRING_FRONT_IRQ_EN
        mres = 16'h00AA;
        wr(3'd2, 32'h201);
        wait_go_low("irq_go_drop");
        @(negedge clk);
        chk("irq_set", {31'd0, bif.irq}, 32'd1);
        wr(3'd4, 32'h10000);
        @(negedge clk);
        chk("irq_clr", {31'd0, bif.irq}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
